puzzle_move_engine: RTL



---
 rtl/puzzle_move_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/puzzle_move_engine.sv
// rtl/puzzle_move_engine.sv - 8-puzzle blank-tile move sequencer driving the board register file
// Reads current/goal boards, validates and applies one blank move, bumps depth, reports solved.
module puzzle_move_engine #(
  parameter int AW         = 5,
  parameter int DW         = 36,
  parameter int CUR_ADDR   = 0,
  parameter int GOAL_ADDR  = 1,
  parameter int DEPTH_ADDR = 3,
  parameter int MAX_DEPTH  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    dir,
  output logic          busy,
  output logic          done,
  output logic          legal,
  output logic          solved,
  output logic [AW-1:0] src0,
  output logic [AW-1:0] src1,
  input  logic [DW-1:0] rdata0,
  input  logic [DW-1:0] rdata1,
  output logic [AW-1:0] dst,
  output logic          we,
  output logic [DW-1:0] wdata
);

  localparam logic [AW-1:0] CUR_A   = AW'(CUR_ADDR);
  localparam logic [AW-1:0] GOAL_A  = AW'(GOAL_ADDR);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_FIND, S_SWAP, S_WB_BOARD, S_RD_DEPTH, S_WB_DEPTH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [DW-1:0] board_q, board_d;
  logic [DW-1:0] goal_q, goal_d;
  logic [DW-1:0] newboard_q, newboard_d;
  logic [3:0]    pos_q, pos_d;
  logic [AW-1:0] src0_q, src0_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic          legal_q, legal_d;
  logic          solved_q, solved_d;

  // Tile i sits at bits [35-4i : 32-4i], so its LSB is 32-4i.
  function automatic logic [5:0] nib_lsb(input logic [3:0] idx);
    return 6'd32 - {idx, 2'b00};
  endfunction

  logic          blank_found;
  logic [3:0]    blank_pos;
  logic          move_ok;
  logic [3:0]    target;
  logic [DW-1:0] swapped;
  logic [4:0]    depth_inc;
  logic [3:0]    depth_sat;

  // Scan downward so the lowest zero nibble wins on boards with duplicates.
  always_comb begin
    blank_found = 1'b0;
    blank_pos   = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (board_q[nib_lsb(4'(i)) +: 4] == 4'd0) begin
        blank_found = 1'b1;
        blank_pos   = 4'(i);
      end
    end
  end

  always_comb begin
    move_ok = blank_found;
    case (dir_q)
      2'b00:   if (blank_pos < 4'd3) move_ok = 1'b0;
      2'b01:   if (blank_pos > 4'd5) move_ok = 1'b0;
      2'b10:   if (blank_pos == 4'd0 || blank_pos == 4'd3 || blank_pos == 4'd6) move_ok = 1'b0;
      default: if (blank_pos == 4'd2 || blank_pos == 4'd5 || blank_pos == 4'd8) move_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (dir_q)
      2'b00:   target = pos_q - 4'd3;
      2'b01:   target = pos_q + 4'd3;
      2'b10:   target = pos_q - 4'd1;
      default: target = pos_q + 4'd1;
    endcase
    swapped = board_q;
    swapped[nib_lsb(pos_q) +: 4]  = board_q[nib_lsb(target) +: 4];
    swapped[nib_lsb(target) +: 4] = board_q[nib_lsb(pos_q) +: 4];
  end

  assign depth_inc = {1'b0, rdata0[3:0]} + 5'd1;
  assign depth_sat = (depth_inc > 5'(MAX_DEPTH)) ? 4'(MAX_DEPTH) : depth_inc[3:0];

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    board_d    = board_q;
    goal_d     = goal_q;
    newboard_d = newboard_q;
    pos_d      = pos_q;
    src0_d     = src0_q;
    dst_d      = dst_q;
    wdata_d    = wdata_q;
    legal_d    = legal_q;
    solved_d   = solved_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          dir_d   = dir;
        end
      end
      S_READ: begin
        board_d = rdata0;
        goal_d  = rdata1;
        state_d = S_FIND;
      end
      S_FIND: begin
        pos_d = blank_pos;
        if (move_ok) begin
          state_d = S_SWAP;
        end else begin
          state_d  = S_DONE;
          legal_d  = 1'b0;
          solved_d = 1'b0;
        end
      end
      S_SWAP: begin
        newboard_d = swapped;
        dst_d      = CUR_A;
        wdata_d    = swapped;
        state_d    = S_WB_BOARD;
      end
      S_WB_BOARD: begin
        src0_d  = DEPTH_A;
        state_d = S_RD_DEPTH;
      end
      S_RD_DEPTH: begin
        src0_d  = CUR_A;
        dst_d   = DEPTH_A;
        wdata_d = {{(DW-4){1'b0}}, depth_sat};
        state_d = S_WB_DEPTH;
      end
      S_WB_DEPTH: begin
        legal_d  = 1'b1;
        solved_d = (newboard_q == goal_q);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status strobes are registered copies of the state being entered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    we_d   = (state_d == S_WB_BOARD) || (state_d == S_WB_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dir_q      <= 2'b00;
      board_q    <= '0;
      goal_q     <= '0;
      newboard_q <= '0;
      pos_q      <= 4'd0;
      src0_q     <= CUR_A;
      dst_q      <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      legal_q    <= 1'b0;
      solved_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      board_q    <= board_d;
      goal_q     <= goal_d;
      newboard_q <= newboard_d;
      pos_q      <= pos_d;
      src0_q     <= src0_d;
      dst_q      <= dst_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      legal_q    <= legal_d;
      solved_q   <= solved_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign legal  = legal_q;
  assign solved = solved_q;
  assign src0   = src0_q;
  assign src1   = GOAL_A;
  assign dst    = dst_q;
  assign we     = we_q;
  assign wdata  = wdata_q;

endmodule
